// File: rtl/wptr_full_if.sv
// Write-side bundle between the producer, the async comparator and wptr_full.
// Stats signals exist only when WPTR_FULL_STATS_EN is defined.
interface wptr_full_if #(
    parameter int ADDR_WD = 4,
    parameter int CNT_WD  = 16
);
    logic               winc;
    logic               afull_n;
    logic               woverflow_clr;
    logic               wen;
    logic [ADDR_WD-1:0] waddr;
    logic [ADDR_WD-1:0] wptr;
    logic               wfull;
    logic               woverflow;
`ifdef WPTR_FULL_STATS_EN
    logic               stats_clr;
    logic [CNT_WD-1:0]  wr_acc_cnt;
    logic [CNT_WD-1:0]  wr_rej_cnt;

    modport master (
        output winc, afull_n, woverflow_clr, stats_clr,
        input  wen, waddr, wptr, wfull, woverflow, wr_acc_cnt, wr_rej_cnt
    );
    modport slave (
        input  winc, afull_n, woverflow_clr, stats_clr,
        output wen, waddr, wptr, wfull, woverflow, wr_acc_cnt, wr_rej_cnt
    );
`else
    modport master (
        output winc, afull_n, woverflow_clr,
        input  wen, waddr, wptr, wfull, woverflow
    );
    modport slave (
        input  winc, afull_n, woverflow_clr,
        output wen, waddr, wptr, wfull, woverflow
    );
`endif
endinterface

// File: rtl/wptr_full.sv
// Write pointer (binary + Gray) and full flag for the async-comparison FIFO; optional stats via WPTR_FULL_STATS_EN.
// Latency: accepted write moves waddr/wptr next edge; wfull sets asynchronously, clears on 2nd edge.
// Backpressure: wen = winc & ~wfull; writes while full are dropped and latched in woverflow.
module wptr_full #(
    parameter int ADDR_WD = 4,
    parameter int CNT_WD  = 16
) (
    input  logic         wclk,
    input  logic         wrst_n,
    wptr_full_if.slave   bus
);
    logic [ADDR_WD-1:0] r_wbin;
    logic [ADDR_WD-1:0] r_wgray;
    logic [ADDR_WD-1:0] w_bnext;
    logic [ADDR_WD-1:0] w_gnext;
    logic               r_wq1;
    logic               r_wq2;
    logic               r_woverflow;
    logic               w_wen;
    logic               w_afull_n;
    logic               w_wrej;

    assign w_afull_n = bus.afull_n;
    assign w_wen     = bus.winc & ~r_wq2;
    assign w_wrej    = bus.winc & r_wq2;
    assign w_bnext   = r_wbin + {{(ADDR_WD-1){1'b0}}, w_wen};
    assign w_gnext   = (w_bnext >> 1) ^ w_bnext;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_wbin  <= '0;
            r_wgray <= '0;
        end else begin
            r_wbin  <= w_bnext;
            r_wgray <= w_gnext;
        end
    end

    // afull_n is an async set, so full asserts without a clock; release is
    // deliberately two edges late so a racing pointer update cannot glitch it.
    always_ff @(posedge wclk or negedge w_afull_n) begin
        if (!w_afull_n) begin
            r_wq1 <= 1'b1;
            r_wq2 <= 1'b1;
        end else if (!wrst_n) begin
            r_wq1 <= 1'b0;
            r_wq2 <= 1'b0;
        end else begin
            r_wq1 <= 1'b0;
            r_wq2 <= r_wq1;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_woverflow <= 1'b0;
        end else if (w_wrej) begin
            r_woverflow <= 1'b1;
        end else if (bus.woverflow_clr) begin
            r_woverflow <= 1'b0;
        end
    end

    assign bus.wen       = w_wen;
    assign bus.waddr     = r_wbin;
    assign bus.wptr      = r_wgray;
    assign bus.wfull     = r_wq2;
    assign bus.woverflow = r_woverflow;

`ifdef WPTR_FULL_STATS_EN
    logic [CNT_WD-1:0] r_acc_cnt;
    logic [CNT_WD-1:0] r_rej_cnt;

    // Saturating counters; clear has priority over increment.
    always_ff @(posedge wclk) begin
        if (!wrst_n || bus.stats_clr) begin
            r_acc_cnt <= '0;
            r_rej_cnt <= '0;
        end else begin
            if (w_wen && !(&r_acc_cnt)) begin
                r_acc_cnt <= r_acc_cnt + 1'b1;
            end
            if (w_wrej && !(&r_rej_cnt)) begin
                r_rej_cnt <= r_rej_cnt + 1'b1;
            end
        end
    end

    assign bus.wr_acc_cnt = r_acc_cnt;
    assign bus.wr_rej_cnt = r_rej_cnt;
`else
    if (CNT_WD < 1) begin : g_cnt_wd_chk
        $error("wptr_full: CNT_WD must be at least 1");
    end
`endif
endmodule

// File: tb/tb_wptr_full.sv
// Scoreboard bench for wptr_full: expected pointer/flag state queued per edge, popped after it.
module tb_wptr_full;
    localparam int AW = 4;
`ifdef WPTR_FULL_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [AW-1:0] wptr;
        logic          wfull;
        logic          woverflow;
    } exp_t;

    logic wclk = 1'b0;
    logic wrst_n;
    always #5 wclk = ~wclk;

    wptr_full_if #(.ADDR_WD(AW), .CNT_WD(CW)) bus ();

    wptr_full #(.ADDR_WD(AW), .CNT_WD(CW)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    exp_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [AW-1:0] gtab [16];
    logic [AW-1:0] m_bin;
    logic          m_q1, m_q2, m_ovf;
    logic [AW-1:0] prev_ptr;
`ifdef WPTR_FULL_STATS_EN
    logic [CW-1:0] m_acc, m_rej;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One wclk edge: predict from pre-edge inputs, queue, then pop and compare.
    task automatic cycle();
        exp_t e;
        logic we;
        logic was_rst;
        #1;
        we      = bus.winc & ~m_q2;
        was_rst = ~wrst_n;
        chk("wen", {31'd0, bus.wen}, {31'd0, we});
        if (!wrst_n) m_ovf = 1'b0;
        else if (bus.winc && m_q2) m_ovf = 1'b1;
        else if (bus.woverflow_clr) m_ovf = 1'b0;
`ifdef WPTR_FULL_STATS_EN
        if (!wrst_n || bus.stats_clr) begin
            m_acc = '0;
            m_rej = '0;
        end else begin
            if (we && m_acc != {CW{1'b1}}) m_acc = m_acc + 1'b1;
            if (bus.winc && m_q2 && m_rej != {CW{1'b1}}) m_rej = m_rej + 1'b1;
        end
`endif
        if (!wrst_n) m_bin = '0;
        else m_bin = m_bin + {{(AW-1){1'b0}}, we};
        if (!bus.afull_n) begin
            m_q1 = 1'b1;
            m_q2 = 1'b1;
        end else if (!wrst_n) begin
            m_q1 = 1'b0;
            m_q2 = 1'b0;
        end else begin
            m_q2 = m_q1;
            m_q1 = 1'b0;
        end
        e = '{waddr: m_bin, wptr: gtab[m_bin], wfull: m_q2, woverflow: m_ovf};
        sb_q.push_back(e);
        @(posedge wclk);
        #1;
        e = sb_q.pop_front();
        chk("waddr", {28'd0, bus.waddr}, {28'd0, e.waddr});
        chk("wptr", {28'd0, bus.wptr}, {28'd0, e.wptr});
        chk("wfull", {31'd0, bus.wfull}, {31'd0, e.wfull});
        chk("woverflow", {31'd0, bus.woverflow}, {31'd0, e.woverflow});
        if (!was_rst)
            chk("gray_step", ($countones(prev_ptr ^ bus.wptr) <= 1) ? 32'd1 : 32'd0, 32'd1);
        prev_ptr = bus.wptr;
`ifdef WPTR_FULL_STATS_EN
        chk("wr_acc_cnt", {{(32-CW){1'b0}}, bus.wr_acc_cnt}, {{(32-CW){1'b0}}, m_acc});
        chk("wr_rej_cnt", {{(32-CW){1'b0}}, bus.wr_rej_cnt}, {{(32-CW){1'b0}}, m_rej});
`endif
    endtask

    initial begin
        gtab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        wrst_n            = 1'b0;
        bus.winc          = 1'b0;
        bus.afull_n       = 1'b1;
        bus.woverflow_clr = 1'b0;
`ifdef WPTR_FULL_STATS_EN
        bus.stats_clr = 1'b0;
        m_acc         = '0;
        m_rej         = '0;
`endif
        m_bin    = '0;
        m_q1     = 1'b0;
        m_q2     = 1'b0;
        m_ovf    = 1'b0;
        prev_ptr = '0;

        // Reset state after the first edge
        @(posedge wclk);
        #1;
        chk("rst_waddr", {28'd0, bus.waddr}, 32'd0);
        chk("rst_wptr", {28'd0, bus.wptr}, 32'd0);
        chk("rst_wfull", {31'd0, bus.wfull}, 32'd0);
        chk("rst_woverflow", {31'd0, bus.woverflow}, 32'd0);

        // Held in reset with winc high: pointers stay at zero
        bus.winc = 1'b1;
        repeat (2) cycle();

        // Full wrap: 17 accepted writes, 0..15 then 0 and on to 1
        wrst_n = 1'b1;
        repeat (17) cycle();

        // afull_n drops between edges: wfull rises without a clock
        bus.afull_n = 1'b0;
        m_q1 = 1'b1;
        m_q2 = 1'b1;
        #2;
        chk("async_wfull", {31'd0, bus.wfull}, 32'd1);
        chk("async_wen", {31'd0, bus.wen}, 32'd0);
        cycle();

        // Release: still full after edge 1, winc at edge 2 rejected, edge 3 accepted
        bus.afull_n = 1'b1;
        bus.winc    = 1'b0;
        cycle();
        bus.winc = 1'b1;
        cycle();
        cycle();

        // Overflow set and clear together: set wins; clear alone then drops it
        bus.afull_n = 1'b0;
        m_q1 = 1'b1;
        m_q2 = 1'b1;
        bus.woverflow_clr = 1'b1;
        cycle();
        bus.afull_n = 1'b1;
        bus.winc    = 1'b0;
        cycle();
        bus.woverflow_clr = 1'b0;
        repeat (2) cycle();

        // Reset mid-burst, then async set must override reset
        bus.winc = 1'b1;
        repeat (3) cycle();
        wrst_n = 1'b0;
        cycle();
        bus.afull_n = 1'b0;
        m_q1 = 1'b1;
        m_q2 = 1'b1;
        cycle();
        bus.afull_n = 1'b1;
        repeat (2) cycle();
        wrst_n = 1'b1;
        repeat (2) cycle();

`ifdef WPTR_FULL_STATS_EN
        // Saturation at CNT_WD=2 after 5 writes, then stats_clr
        wrst_n = 1'b0;
        cycle();
        wrst_n = 1'b1;
        repeat (5) cycle();
        chk("acc_saturated", {{(32-CW){1'b0}}, bus.wr_acc_cnt}, 32'd3);
        bus.winc      = 1'b0;
        bus.stats_clr = 1'b1;
        cycle();
        chk("acc_cleared", {{(32-CW){1'b0}}, bus.wr_acc_cnt}, 32'd0);
        bus.stats_clr = 1'b0;
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-side pointer and full-flag controller for the asynchronous-comparison async FIFO.
- Owns the binary write address and the Gray-coded write pointer, which goes to the async comparator.
- Gates write requests into a memory write enable.
- Derives a glitch-safe wfull from the comparator's asynchronous afull_n, and flags writes attempted while full.

Parameters:
- ADDR_WD, 4: pointer/address width; FIFO depth = 2**ADDR_WD.
- CNT_WD, 16: statistics counter width (used only with WPTR_FULL_STATS_EN).

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  synchronous active-low reset; sampled on the wclk rising edge.
- winc  input  1  write request from producer.
- afull_n  input  1  asynchronous active-low "going full" indication from the comparator; acts as an asynchronous set of the full synchronizer, never as a reset.
- woverflow_clr  input  1  synchronous clear of the sticky overflow flag.
- wen  output  1  memory write enable = winc & ~wfull (combinational).
- waddr  output  ADDR_WD  binary write address to the FIFO memory (registered).
- wptr  output  ADDR_WD  Gray-coded write pointer to the comparator (registered).
- wfull  output  1  FIFO full.
- woverflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (wrst_n low at a wclk edge):
  - waddr = 0, wptr = 0, woverflow = 0.
  - Full synchronizer cleared to 00, so wfull = 0, unless afull_n is low (see asynchronous set).
- Pointer update, every wclk edge out of reset:
  - wbnext = wbin + wen, modulo 2**ADDR_WD.
  - wgnext = (wbnext >> 1) ^ wbnext.
  - {wbin, wgray} <= {wbnext, wgnext}.
- Latency and wrap:
  - An accepted write advances waddr and wptr one cycle later.
  - wptr changes exactly one bit per accepted write.
  - Wrap-around is natural: waddr 2**ADDR_WD-1 -> 0, Gray 100..0 -> 000..0.
- Full synchronizer: two flops wq1, wq2; wfull = wq2.
  - Asynchronous set: afull_n low forces wq1 = wq2 = 1 immediately, overriding the clock and the synchronous reset.
  - Otherwise each edge: wq1 <= ~afull_n (0), wq2 <= wq1.
  - Assertion: wfull goes high with no clock dependency once afull_n falls.
  - Deassertion: wfull falls on the 2nd wclk edge after afull_n rises. This pessimistic release is required.
- Write gating:
  - winc while wfull: no memory write (wen = 0), pointers hold.
  - woverflow is set at that edge.
- Overflow flag:
  - Set on any edge with winc & wfull.
  - Cleared by woverflow_clr.
  - Set and clear in the same cycle: set wins.
  - Reset clears it.
- Simultaneous events:
  - winc on the same edge that wfull releases: wen uses the pre-edge wfull (still 1), so the write is rejected.
  - Reset asserted mid-burst: pointers zero at that edge regardless of winc.
- No other state machine; all state sits in the wbin/wgray/wq1/wq2/woverflow registers.

Optional Feature:
- Macro: WPTR_FULL_STATS_EN.
- When defined, adds:
  - Input stats_clr (1).
  - Outputs wr_acc_cnt (CNT_WD), counting edges with wen = 1.
  - Outputs wr_rej_cnt (CNT_WD), counting edges with winc & wfull.
- Counter rules:
  - Both counters saturate at all-ones and do not wrap.
  - Both are cleared synchronously by reset or stats_clr; clear wins over increment.
- When undefined:
  - These ports and counters do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset with afull_n=1 -> waddr=0, wptr=0, wfull=0, woverflow=0 after first edge; held in reset with winc=1 -> pointers stay 0.
- 16 consecutive winc, afull_n=1, ADDR_WD=4 -> waddr 0..15 then 0; wptr sequence 0,1,3,2,6,...,8,0; exactly one bit toggles per step.
- Drop afull_n mid-cycle -> wfull=1 before next edge; with winc=1 -> wen=0, waddr holds, woverflow=1 next edge.
- Raise afull_n -> wfull stays 1 at edge 1, 0 after edge 2; winc at edge 2 is rejected; winc at edge 3 is accepted.
- woverflow=1, assert woverflow_clr together with winc&wfull -> woverflow stays 1; clr alone -> 0 next edge.
- WPTR_FULL_STATS_EN, CNT_WD=2: 5 accepted writes -> wr_acc_cnt=3 (saturated); stats_clr -> 0.
